// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: shadowed digits, guard band, LZ blanking, blink.
// Latency: seg/dp/an are registered one cycle behind scan state; free-running, no backpressure.
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 8,
  parameter int HEX_EN       = 0,
  parameter int ACTIVE_LOW   = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] val,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] DIG_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] GUARD_C    = CW'(GUARD);

  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [CW-1:0]           r_scan_cnt;
  logic [IW-1:0]           r_digit_idx;
  logic [FW-1:0]           r_frame_cnt;
  logic                    r_blink_phase;
  logic                    r_frame_tick;
  logic [6:0]              r_seg;
  logic                    r_dp_o;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                  w_scan_end;
  logic                  w_frame_end;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_blink_sel;
  logic                  w_lz_blank;
  logic                  w_zero_run;
  logic                  w_suppress;
  logic [NUM_DIGITS-1:0] w_onehot;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] hex;
    hex = 7'h00;
    case (nib)
      4'h0: f_decode = 7'h3F;
      4'h1: f_decode = 7'h06;
      4'h2: f_decode = 7'h5B;
      4'h3: f_decode = 7'h4F;
      4'h4: f_decode = 7'h66;
      4'h5: f_decode = 7'h6D;
      4'h6: f_decode = 7'h7D;
      4'h7: f_decode = 7'h07;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h6F;
      default: begin
        case (nib)
          4'hA:    hex = 7'h77;
          4'hB:    hex = 7'h7C;
          4'hC:    hex = 7'h39;
          4'hD:    hex = 7'h5E;
          4'hE:    hex = 7'h79;
          default: hex = 7'h71;
        endcase
        f_decode = (HEX_EN != 0) ? hex : 7'h00;
      end
    endcase
  endfunction

  assign w_scan_end  = (r_scan_cnt == SCAN_LAST);
  assign w_frame_end = w_scan_end && (r_digit_idx == DIG_LAST);
  assign w_onehot    = NUM_DIGITS'(1) << r_digit_idx;

  // Walk from the top digit down so w_zero_run means "this and all higher nibbles are zero".
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blink_sel = 1'b0;
    w_lz_blank  = 1'b0;
    w_zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_val[4*i +: 4] == 4'h0);
      if (r_digit_idx == IW'(i)) begin
        w_nib       = r_val[4*i +: 4];
        w_dp_sel    = r_dp[i];
        w_blink_sel = blink_en[i];
        w_lz_blank  = blank_lz && w_zero_run && (i != 0);
      end
    end
  end

  assign w_suppress = (r_scan_cnt < GUARD_C) || w_lz_blank || (w_blink_sel && r_blink_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      r_dp  <= '0;
    end else if (load) begin
      r_val <= val;
      r_dp  <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt    <= '0;
      r_digit_idx   <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_scan_end) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      if (w_frame_end) begin
        if (r_frame_cnt == BLINK_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // Pin polarity is folded in before the flops so the pins never glitch between slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an   <= {NUM_DIGITS{POL}};
      r_seg  <= {7{POL}};
      r_dp_o <= POL;
    end else if (w_suppress) begin
      r_an   <= {NUM_DIGITS{POL}};
      r_seg  <= {7{POL}};
      r_dp_o <= POL;
    end else begin
      r_an   <= w_onehot ^ {NUM_DIGITS{POL}};
      r_seg  <= f_decode(w_nib) ^ {7{POL}};
      r_dp_o <= w_dp_sel ^ POL;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp_o;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: cycle-indexed reference model feeds a scoreboard queue per clock.
module tb_seg7_scan_mux;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int GD = 1;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   val = '0;
  logic [3:0]    dp_in = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [3:0]    blink_en = '0;
  logic [6:0]    seg0, seg1;
  logic          dp0, dp1, ft0, ft1;
  logic [3:0]    an0, an1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_hex;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        ex;
  int          n_checks = 0;
  int          n_fail = 0;
  int          k = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .HEX_EN(0),
                  .ACTIVE_LOW(1), .BLINK_FRAMES(BF)) u_dut (
    .clk(clk), .rst_n(rst_n), .val(val), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0));

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .HEX_EN(1),
                  .ACTIVE_LOW(1), .BLINK_FRAMES(BF)) u_dut_hex (
    .clk(clk), .rst_n(rst_n), .val(val), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1));

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n, input bit hex);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return hex ? 7'h77 : 7'h00;
      4'hB: return hex ? 7'h7C : 7'h00;
      4'hC: return hex ? 7'h39 : 7'h00;
      4'hD: return hex ? 7'h5E : 7'h00;
      4'hE: return hex ? 7'h79 : 7'h00;
      default: return hex ? 7'h71 : 7'h00;
    endcase
  endfunction

  // Expected pins just after clock edge kk (counted from reset release), from elapsed time alone.
  function automatic exp_t model(input int kk);
    exp_t       e;
    int         c, sc, d, ph;
    logic [3:0] nib;
    bit         lzb, sup;
    c   = kk - 1;
    sc  = c % SD;
    d   = (c / SD) % ND;
    ph  = ((c / (SD * ND)) / BF) % 2;
    nib = m_val[4*d +: 4];
    lzb = blank_lz && (d > 0) && ((m_val >> (4*d)) == 16'h0);
    sup = (sc < GD) || lzb || (blink_en[d] && ph == 1);
    e.ft = ((kk % (SD * ND)) == 0);
    if (sup) begin
      e.an = 4'hF; e.seg = 7'h7F; e.seg_hex = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an      = 4'hF;
      e.an[d]   = 1'b0;
      e.seg     = ~ref_seg(nib, 1'b0);
      e.seg_hex = ~ref_seg(nib, 1'b1);
      e.dp      = ~m_dp[d];
    end
    return e;
  endfunction

  task automatic tick();
    sb_q.push_back(model(k + 1));
    if (load) begin
      m_val = val;
      m_dp  = dp_in;
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0; m_val = '0; m_dp = '0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({an0, seg0, dp0, ft0} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: an=%b seg=%h dp=%b ft=%b, want 1111 7f 1 0", an0, seg0, dp0, ft0);
    end
    n_checks++;
    if ({an1, seg1, dp1} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state_hex: an=%b seg=%h dp=%b, want 1111 7f 1", an1, seg1, dp1);
    end
    val = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    restart();
    tick();
    load = 1'b0;
    ex = sb_q.pop_front();
    n_checks++;
    if ({an0, seg0, dp0, ft0} !== {ex.an, ex.seg, ex.dp, ex.ft}) begin
      n_fail++;
      $display("FAIL first_cycle: an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
               an0, seg0, dp0, ft0, ex.an, ex.seg, ex.dp, ex.ft);
    end
  endtask

  task automatic test_scan_sequence();
    int ft_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      ex = sb_q.pop_front();
      if (ft0) ft_cnt++;
      n_checks++;
      if ({an0, seg0, dp0, ft0} !== {ex.an, ex.seg, ex.dp, ex.ft}) begin
        n_fail++;
        $display("FAIL scan k=%0d: an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                 k, an0, seg0, dp0, ft0, ex.an, ex.seg, ex.dp, ex.ft);
      end
    end
    n_checks++;
    if (ft_cnt != 2) begin
      n_fail++;
      $display("FAIL frame_tick_count: got %0d pulses in 32 cycles, want 2", ft_cnt);
    end
  endtask

  task automatic test_hex();
    val = 16'h123A; dp_in = 4'b0001; load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      load = 1'b0;
      ex = sb_q.pop_front();
      n_checks++;
      if ({an0, seg0, dp0, an1, seg1} !== {ex.an, ex.seg, ex.dp, ex.an, ex.seg_hex}) begin
        n_fail++;
        $display("FAIL hex k=%0d: an=%b seg=%h dp=%b hex_an=%b hex_seg=%h, want an=%b seg=%h dp=%b hex_seg=%h",
                 k, an0, seg0, dp0, an1, seg1, ex.an, ex.seg, ex.dp, ex.seg_hex);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0000};
    bit          lzs  [3] = '{1'b1, 1'b1, 1'b0};
    for (int p = 0; p < 3; p++) begin
      val = vals[p]; blank_lz = lzs[p]; dp_in = 4'b0101; load = 1'b1;
      for (int i = 0; i < 16; i++) begin
        tick();
        load = 1'b0;
        ex = sb_q.pop_front();
        n_checks++;
        if ({an0, seg0, dp0, ft0} !== {ex.an, ex.seg, ex.dp, ex.ft}) begin
          n_fail++;
          $display("FAIL lz p=%0d k=%0d: an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                   p, k, an0, seg0, dp0, ft0, ex.an, ex.seg, ex.dp, ex.ft);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    bit seen  = 0;
    val = 16'h4321; load = 1'b1;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      load = 1'b0;
      ex = sb_q.pop_front();
      if (an0 == 4'b1011) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL digit2_reached: an never 1011 within 64 cycles, want 1011");
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an0, seg0, dp0, ft0} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: an=%b seg=%h dp=%b ft=%b, want 1111 7f 1 0", an0, seg0, dp0, ft0);
    end
    restart();
    for (int i = 0; i < 8; i++) begin
      tick();
      ex = sb_q.pop_front();
      if (!seen && an0 != 4'hF) begin
        seen = 1;
        n_checks++;
        if (an0 !== 4'b1110) begin
          n_fail++;
          $display("FAIL restart_first_anode: an=%b, want 1110", an0);
        end
      end
      n_checks++;
      if ({an0, seg0, dp0, ft0} !== {ex.an, ex.seg, ex.dp, ex.ft}) begin
        n_fail++;
        $display("FAIL restart k=%0d: an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                 k, an0, seg0, dp0, ft0, ex.an, ex.seg, ex.dp, ex.ft);
      end
    end
  endtask

  task automatic test_blink();
    int lit [6] = '{0, 0, 0, 0, 0, 0};
    int want;
    #2;
    rst_n = 1'b0;
    val = 16'h8888; dp_in = 4'b0000; blink_en = 4'b0010; load = 1'b1;
    restart();
    for (int i = 0; i < 96; i++) begin
      tick();
      load = 1'b0;
      ex = sb_q.pop_front();
      if (an0 == 4'b1101) lit[(k - 1) / 16]++;
      n_checks++;
      if ({an0, seg0, dp0, ft0} !== {ex.an, ex.seg, ex.dp, ex.ft}) begin
        n_fail++;
        $display("FAIL blink k=%0d: an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                 k, an0, seg0, dp0, ft0, ex.an, ex.seg, ex.dp, ex.ft);
      end
    end
    for (int f = 0; f < 6; f++) begin
      want = (f == 2 || f == 3) ? 0 : 3;
      n_checks++;
      if (lit[f] != want) begin
        n_fail++;
        $display("FAIL blink_frame%0d: digit1 lit %0d cycles, want %0d", f, lit[f], want);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) begin
      val = 16'($urandom); dp_in = 4'($urandom); blink_en = 4'($urandom);
      blank_lz = 1'($urandom); load = 1'($urandom_range(0, 1));
      if (i % 5 == 0) val = 16'($urandom_range(0, 15));
      tick();
      ex = sb_q.pop_front();
      n_checks++;
      if ({an0, seg0, dp0, ft0, an1, seg1} !== {ex.an, ex.seg, ex.dp, ex.ft, ex.an, ex.seg_hex}) begin
        n_fail++;
        $display("FAIL b2b k=%0d: an=%b seg=%h dp=%b ft=%b hex_seg=%h, want an=%b seg=%h dp=%b ft=%b hex_seg=%h",
                 k, an0, seg0, dp0, ft0, seg1, ex.an, ex.seg, ex.dp, ex.ft, ex.seg_hex);
      end
      n_checks++;
      if ($countones(~an0) > 1) begin
        n_fail++;
        $display("FAIL onehot k=%0d: an=%b, want at most one active", k, an0);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_sequence();
    test_hex();
    test_leading_zero();
    test_async_reset();
    test_blink();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
